psg_register_bus: RTL and testbench



---
 rtl/psg_register_bus.sv | 149 ++++++++++++++
 tb/tb_psg_register_bus.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/psg_register_bus.sv
// SN76489-style write port and control registers: latch/data byte decode plus READY emulation.
// Optional PSG_WE_SYNC_EN adds a 2-flop synchronizer on we_n/data ahead of edge detection.
module psg_register_bus #(
  parameter int NUM_TONES                = 3,
  parameter int ATTENUATION_CONTROL_BITS = 4,
  parameter int TONE_FREQUENCY_BITS      = 10,
  parameter int NOISE_CONTROL_BITS       = 3,
  parameter int WRITE_CYCLES             = 32
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [7:0]                                        data,
  input  logic                                              we_n,
  output logic                                              ready,
  output logic [(NUM_TONES+1)*ATTENUATION_CONTROL_BITS-1:0] attn_flat,
  output logic [NUM_TONES*TONE_FREQUENCY_BITS-1:0]          tone_freq_flat,
  output logic [NOISE_CONTROL_BITS-1:0]                     noise_ctrl,
  output logic                                              noise_reset_lfsr
);

  localparam int AB = ATTENUATION_CONTROL_BITS;
  localparam int TB = TONE_FREQUENCY_BITS;
  localparam int NB = NOISE_CONTROL_BITS;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e                              state_q, state_d;
  logic [7:0]                          cnt_q, cnt_d;
  logic                                we_n_q;
  logic [NUM_TONES:0][AB-1:0]          attn_q, attn_d;
  logic [NUM_TONES-1:0][TB-1:0]        tone_q, tone_d;
  logic [NB-1:0]                       noise_q, noise_d;
  logic [1:0]                          ch_q, ch_d;
  logic                                type_q, type_d;
  logic                                nrl_q, nrl_d;
  logic                                we_s;
  logic [7:0]                          data_s;
  logic                                accept;

`ifdef PSG_WE_SYNC_EN
  logic [1:0]      we_sync_q;
  logic [1:0][7:0] data_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      we_sync_q   <= 2'b11;
      data_sync_q <= '0;
    end else begin
      we_sync_q   <= {we_sync_q[0], we_n};
      data_sync_q <= {data_sync_q[0], data};
    end
  end

  assign we_s   = we_sync_q[1];
  assign data_s = data_sync_q[1];
`else
  assign we_s   = we_n;
  assign data_s = data;
`endif

  // Falling edges seen while BUSY are dropped; we_n_q keeps tracking so a held strobe never retriggers.
  assign accept = we_n_q & ~we_s & (state_q == IDLE) & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_n_q  <= we_s;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = BUSY;
        cnt_d   = 8'(WRITE_CYCLES - 1);
      end
      BUSY: if (cnt_q == 8'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 8'd1;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == IDLE);
  end

  always_comb begin
    attn_d  = attn_q;
    tone_d  = tone_q;
    noise_d = noise_q;
    ch_d    = ch_q;
    type_d  = type_q;
    nrl_d   = 1'b0;
    if (accept) begin
      if (data_s[7]) begin
        ch_d   = data_s[6:5];
        type_d = data_s[4];
        if (data_s[4]) begin
          attn_d[data_s[6:5]] = AB'(data_s[3:0]);
        end else if (data_s[6:5] == 2'(NUM_TONES)) begin
          noise_d = NB'(data_s[2:0]);
          nrl_d   = 1'b1;
        end else begin
          tone_d[data_s[6:5]][3:0] = data_s[3:0];
        end
      end else begin
        if (type_q) begin
          attn_d[ch_q] = AB'(data_s[3:0]);
        end else if (ch_q == 2'(NUM_TONES)) begin
          noise_d = NB'(data_s[2:0]);
          nrl_d   = 1'b1;
        end else begin
          tone_d[ch_q][TB-1:4] = (TB-4)'(data_s[5:0]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      attn_q  <= '1;
      tone_q  <= '0;
      noise_q <= '0;
      ch_q    <= '0;
      type_q  <= 1'b0;
      nrl_q   <= 1'b0;
    end else begin
      attn_q  <= attn_d;
      tone_q  <= tone_d;
      noise_q <= noise_d;
      ch_q    <= ch_d;
      type_q  <= type_d;
      nrl_q   <= nrl_d;
    end
  end

  assign attn_flat        = attn_q;
  assign tone_freq_flat   = tone_q;
  assign noise_ctrl       = noise_q;
  assign noise_reset_lfsr = nrl_q;

endmodule

// File: tb/tb_psg_register_bus.sv
// Directed bench for psg_register_bus: byte decode, READY timing, noise pulse, busy/reset handling.
module tb_psg_register_bus;

  logic        clk;
  logic        reset;
  logic [7:0]  data;
  logic        we_n;
  logic        ready;
  logic [15:0] attn_flat;
  logic [29:0] tone_freq_flat;
  logic [2:0]  noise_ctrl;
  logic        noise_reset_lfsr;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef PSG_WE_SYNC_EN
  localparam int LAT      = 2;
  localparam int BUSY_REM = 29;
`else
  localparam int LAT      = 0;
  localparam int BUSY_REM = 27;
`endif

  psg_register_bus dut (
    .clk              (clk),
    .reset            (reset),
    .data             (data),
    .we_n             (we_n),
    .ready            (ready),
    .attn_flat        (attn_flat),
    .tone_freq_flat   (tone_freq_flat),
    .noise_ctrl       (noise_ctrl),
    .noise_reset_lfsr (noise_reset_lfsr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle low strobe; returns #1 after the edge that sampled we_n low.
  task automatic strobe(input logic [7:0] b);
    data = b;
    we_n = 1'b0;
    step();
    we_n = 1'b1;
  endtask

  // Counts low-ready samples and lfsr pulses until READY recovers (bounded).
  task automatic wait_idle(output int low, output int pulses, output int first_low);
    low = 0; pulses = 0; first_low = -1;
    for (int i = 0; i < 200; i++) begin
      if (!ready) begin
        if (first_low < 0) first_low = i;
        low++;
      end
      if (noise_reset_lfsr) pulses++;
      if (ready && low > 0) break;
      step();
    end
  endtask

  initial begin
    int low, pulses, first_low, rdy_hi;
    reset = 1'b1; we_n = 1'b1; data = 8'h00;
    repeat (3) step();
    reset = 1'b0;
    repeat (10) step();
    chk("rst_attn",  32'(attn_flat), 32'h0000FFFF);
    chk("rst_tone",  32'(tone_freq_flat), 32'h0);
    chk("rst_noise", 32'(noise_ctrl), 32'h0);
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_nrl",   32'(noise_reset_lfsr), 32'h0);

    // Tone 0 latch then data byte -> 0x0FE
    strobe(8'h8E);
    wait_idle(low, pulses, first_low);
    chk("t0_latency", 32'(first_low), 32'(LAT));
    chk("t0_busy1",   32'(low), 32'd32);
    chk("t0_nopulse", 32'(pulses), 32'd0);
    chk("t0_lo",      32'(tone_freq_flat), 32'h00E);
    strobe(8'h0F);
    wait_idle(low, pulses, first_low);
    chk("t0_busy2",   32'(low), 32'd32);
    chk("t0_full",    32'(tone_freq_flat), 32'h0FE);

    // Channel 2 attenuation latch then data byte
    strobe(8'hD5);
    wait_idle(low, pulses, first_low);
    chk("a2_latch", 32'(attn_flat), 32'h0000F5FF);
    strobe(8'h03);
    wait_idle(low, pulses, first_low);
    chk("a2_data",  32'(attn_flat), 32'h0000F3FF);

    // Noise latch and data byte, one pulse each
    strobe(8'hE6);
    wait_idle(low, pulses, first_low);
    chk("n_latch",  32'(noise_ctrl), 32'h6);
    chk("n_pulse1", 32'(pulses), 32'd1);
    strobe(8'h05);
    wait_idle(low, pulses, first_low);
    chk("n_data",   32'(noise_ctrl), 32'h5);
    chk("n_pulse2", 32'(pulses), 32'd1);

    // Strobe while BUSY is dropped and does not extend BUSY
    strobe(8'hA7);
    repeat (4) step();
    strobe(8'h9A);
    wait_idle(low, pulses, first_low);
    chk("bz_remain", 32'(low), 32'(BUSY_REM));
    chk("bz_attn",   32'(attn_flat), 32'h0000F3FF);
    chk("bz_tone",   32'(tone_freq_flat), 32'h00001CFE);

    // we_n held low across the end of BUSY: no retrigger
    strobe(8'hC1);
    data = 8'h9A;
    we_n = 1'b0;
    wait_idle(low, pulses, first_low);
    chk("hold_busy", 32'(low), 32'd32);
    rdy_hi = 0;
    for (int i = 0; i < 6; i++) begin
      if (ready) rdy_hi++;
      step();
    end
    we_n = 1'b1;
    step();
    chk("hold_ready", 32'(rdy_hi), 32'd6);
    chk("hold_attn",  32'(attn_flat), 32'h0000F3FF);
    chk("hold_tone",  32'(tone_freq_flat), 32'h00101CFE);

    // Reset five cycles into BUSY
    strobe(8'h80);
    repeat (4) step();
    chk("mid_busy", 32'(ready), 32'h0);
    reset = 1'b1;
    step();
    chk("mr_ready", 32'(ready), 32'h1);
    chk("mr_attn",  32'(attn_flat), 32'h0000FFFF);
    chk("mr_tone",  32'(tone_freq_flat), 32'h0);
    chk("mr_noise", 32'(noise_ctrl), 32'h0);
    chk("mr_nrl",   32'(noise_reset_lfsr), 32'h0);
    reset = 1'b0;
    step();

    // Writes resume after reset with the same latency
    strobe(8'h8E);
    wait_idle(low, pulses, first_low);
    chk("pr_latency", 32'(first_low), 32'(LAT));
    chk("pr_busy",    32'(low), 32'd32);
    chk("pr_tone",    32'(tone_freq_flat), 32'h00E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
